voice_change_frame_player: RTL and testbench
============================================

Name: voice_change_frame_player

Overview:
- Downstream stage of the linear-interpolation pitch-shift resampler.
- Waits for the resampler's frame-complete pulse, then reads the resampled frame out of the resampler's output RAM (10-bit address, 16-bit data, synchronous read, 1-clock latency).
- Plays one sample per audio-rate strobe, with an optional linear fade-in/fade-out at frame edges to suppress boundary clicks.
- Tells the upstream controller when the RAM is free for the next frame.

Parameters:
- DATA_WIDTH, 16, sample width, two's complement.
- ADDR_WIDTH, 10, frame RAM address width.
- FADE_SHIFT, 4, fade ramp length is 2^FADE_SHIFT samples; gain is unity at 2^FADE_SHIFT.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-clock audio-rate strobe; spacing of at least 4 clk is guaranteed by the source.
- frame_done  in  1  frame-complete pulse from the resampler (its flag_end); rising-edge detected internally.
- frame_last  in  ADDR_WIDTH  index of the last valid sample in the frame (the resampler's wr_addr_max); latched at frame start.
- fade_en  in  1  1 = apply edge fades; 0 = unity gain throughout. Sampled per tick.
- rd_addr  out  ADDR_WIDTH  frame RAM read address (registered).
- rd_data  in  DATA_WIDTH  frame RAM read data, valid 1 clk after rd_addr.
- audio_out  out  DATA_WIDTH  output sample (registered).
- audio_valid  out  1  one-clock strobe marking a new audio_out.
- frame_req  out  1  one-clock pulse: last sample has been read, RAM free for the next frame.
- underrun  out  1  one-clock pulse: a tick arrived with no frame available.
- overrun  out  1  sticky: frame_done arrived while a frame was already pending; cleared only by reset.

Behaviour:
- Reset: all outputs 0; state IDLE; pending=0; idx=0; the frame_done edge-detect register is 0.
- Pending flag:
  - Set on a frame_done rising edge.
  - Cleared when a frame starts.
  - If set and cleared in the same clock, set wins.
  - A rising edge while pending=1 sets overrun.
- States:
  - IDLE:
    - tick with pending=1: latch frame_last, idx=0, clear pending, go to PLAY, and process this tick as sample 0.
    - tick with pending=0: emit 0 (audio_valid at tick+3, same as a normal sample); pulse underrun at tick+1.
  - PLAY, on each tick:
    - rd_addr <= idx (registered on the tick edge).
    - If idx == latched last: pulse frame_req at tick+1. Then, if pending=1, start the next frame immediately (next tick is its sample 0); otherwise go to IDLE.
    - Else idx++.
- Pipeline, clock counts relative to the tick edge:
  - t+1: rd_addr valid.
  - t+2: rd_data captured, together with the gain computed for that idx.
  - t+3: audio_out updated and audio_valid high for 1 clk.
  - Fixed latency 3 clk.
- Gain:
  - g = min(idx, last-idx, 2^FADE_SHIFT), unsigned FADE_SHIFT+1 bits.
  - fade_en=0 forces g = 2^FADE_SHIFT.
- Arithmetic:
  - product = signed(rd_data) × g, computed in DATA_WIDTH+FADE_SHIFT+1 bits.
  - audio_out = product >>> FADE_SHIFT (arithmetic shift, rounds toward −inf), truncated to DATA_WIDTH. No overflow is possible since g ≤ 2^FADE_SHIFT.
- Boundaries:
  - last=0: the single sample has g=0; frame_req still pulses.
  - Short frames: ramps overlap; the min() rule governs.
  - rd_addr holds its value between ticks.
  - frame_done during PLAY does not disturb the current frame.
  - Reset mid-frame aborts immediately; no frame_req is issued.

Test Plan:
1. Reset, then frame_done pulse, frame_last=1023, fade_en=0, RAM[i]=i, ticks every 8 clk → audio_out = 0,1,2,… each at tick+3; frame_req once, after the tick for idx 1023; then IDLE.
2. fade_en=1, FADE_SHIFT=4, RAM all -100 → idx0: 0; idx5: -32 (-500>>>4); idx16: -100; idx1018: -32; idx1023: 0.
3. Ticks with no frame_done → audio_out=0 with audio_valid each tick; underrun pulse per tick; rd_addr unchanged.
4. frame_done mid-frame, frame_last=3 → after idx3, frame_req pulses and the next tick plays idx0 of the new frame with no underrun; a second frame_done before that start → overrun=1 and stays 1.
5. frame_last=0, fade_en=1, RAM[0]=1000 → one sample audio_out=0; frame_req pulse; return to IDLE.
6. Assert rst_n low at idx 500 → all outputs 0 at once; after release, underrun on the next tick until a new frame_done arrives.

Source files
------------

// File: rtl/voice_change_frame_player.sv
// Plays a resampled frame out of the resampler RAM, one sample per audio tick, with optional edge fades.
// Latency: 3 clk from sample_tick to audio_valid. No backpressure: the tick source paces everything.
module voice_change_frame_player #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int FADE_SHIFT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_tick,
    input  logic                  frame_done,
    input  logic [ADDR_WIDTH-1:0] frame_last,
    input  logic                  fade_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] audio_out,
    output logic                  audio_valid,
    output logic                  frame_req,
    output logic                  underrun,
    output logic                  overrun
);

    localparam int PW = DATA_WIDTH + FADE_SHIFT + 1;
    localparam logic [FADE_SHIFT:0]   G_UNITY = {1'b1, {FADE_SHIFT{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] A_UNITY = ADDR_WIDTH'(G_UNITY);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d, last_q, last_d, rd_addr_d;
    logic [ADDR_WIDTH-1:0] cur_idx, cur_last, rem, near;
    logic                  pending_q, pending_d, fd_q, rise, start, play_tick;
    logic                  frame_req_d, underrun_d, v_d, v1_q, v2_q;
    logic [FADE_SHIFT:0]   gain, g_d, g1_q, g2_q;
    logic signed [PW-1:0]  data_ext, gain_ext, prod;
    logic [FADE_SHIFT:0]   prod_unused;

    assign rise = frame_done & ~fd_q;

    // Fade gain: distance to the nearer frame edge, saturated at unity.
    always_comb begin
        rem  = cur_last - cur_idx;
        near = (cur_idx < rem) ? cur_idx : rem;
        if (!fade_en || near >= A_UNITY)
            gain = G_UNITY;
        else
            gain = near[FADE_SHIFT:0];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_d      = last_q;
        rd_addr_d   = rd_addr;
        cur_idx     = idx_q;
        cur_last    = last_q;
        start       = 1'b0;
        play_tick   = 1'b0;
        frame_req_d = 1'b0;
        underrun_d  = 1'b0;
        v_d         = 1'b0;
        g_d         = '0;
        if (sample_tick) begin
            v_d = 1'b1;
            if (state_q == IDLE) begin
                if (pending_q) begin
                    start     = 1'b1;
                    play_tick = 1'b1;
                    cur_idx   = '0;
                    cur_last  = frame_last;
                end else begin
                    underrun_d = 1'b1;
                end
            end else begin
                play_tick = 1'b1;
            end
            if (play_tick) begin
                rd_addr_d = cur_idx;
                g_d       = gain;
                if (cur_idx == cur_last) begin
                    frame_req_d = 1'b1;
                    // A frame queued behind this one starts back-to-back.
                    if (pending_q && !start) begin
                        start   = 1'b1;
                        idx_d   = '0;
                        last_d  = frame_last;
                        state_d = PLAY;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d   = cur_idx + 1'b1;
                    last_d  = cur_last;
                    state_d = PLAY;
                end
            end
        end
        pending_d = rise | (pending_q & ~start);
    end

    assign data_ext    = {{(FADE_SHIFT+1){rd_data[DATA_WIDTH-1]}}, rd_data};
    assign gain_ext    = {{DATA_WIDTH{1'b0}}, g2_q};
    assign prod        = data_ext * gain_ext;
    assign prod_unused = {prod[PW-1], prod[FADE_SHIFT-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            last_q      <= '0;
            pending_q   <= 1'b0;
            fd_q        <= 1'b0;
            rd_addr     <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            g1_q        <= '0;
            g2_q        <= '0;
            audio_out   <= '0;
            audio_valid <= 1'b0;
            frame_req   <= 1'b0;
            underrun    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            pending_q   <= pending_d;
            fd_q        <= frame_done;
            rd_addr     <= rd_addr_d;
            v1_q        <= v_d;
            g1_q        <= g_d;
            v2_q        <= v1_q;
            g2_q        <= g1_q;
            audio_valid <= v2_q;
            if (v2_q)
                audio_out <= prod[FADE_SHIFT +: DATA_WIDTH];
            frame_req   <= frame_req_d;
            underrun    <= underrun_d;
            overrun     <= overrun | (rise & pending_q);
        end
    end

endmodule

// File: tb/tb_voice_change_frame_player.sv
// Scoreboard bench for voice_change_frame_player: stimulus pushes expected samples/pulses with their cycle,
// a negedge monitor pops and compares whenever the DUT presents audio_valid, underrun or frame_req.
module tb_voice_change_frame_player;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic        frame_done = 1'b0;
    logic [9:0]  frame_last = '0;
    logic        fade_en = 1'b0;
    logic [9:0]  rd_addr;
    logic [15:0] rd_data = '0;
    logic [15:0] audio_out;
    logic        audio_valid, frame_req, underrun, overrun;

    voice_change_frame_player #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .FADE_SHIFT(4)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .frame_done(frame_done),
        .frame_last(frame_last), .fade_en(fade_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .audio_out(audio_out), .audio_valid(audio_valid), .frame_req(frame_req),
        .underrun(underrun), .overrun(overrun)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [1024];
    always @(posedge clk) rd_data <= ram[rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    int exp_val[$], exp_cyc[$], ur_cyc[$], fr_cyc[$];

    // Reference model of the player state
    bit m_play = 0, m_pending = 0, m_overrun = 0;
    int m_idx = 0, m_last = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin : monitor
        int v, c;
        if (rst_n) begin
            if (audio_valid) begin
                if (exp_val.size() == 0) check("audio_unexpected", 1, 0);
                else begin
                    v = exp_val.pop_front();
                    c = exp_cyc.pop_front();
                    check("audio_val", int'($signed(audio_out)), v);
                    check("audio_cyc", cyc, c);
                end
            end
            if (underrun) begin
                if (ur_cyc.size() == 0) check("underrun_unexpected", 1, 0);
                else check("underrun_cyc", cyc, ur_cyc.pop_front());
            end
            if (frame_req) begin
                if (fr_cyc.size() == 0) check("frame_req_unexpected", 1, 0);
                else check("frame_req_cyc", cyc, fr_cyc.pop_front());
            end
        end
    end

    function automatic int model_gain(int i, int l, bit f);
        int m;
        if (!f) return 16;
        m = i;
        if (l - i < m) m = l - i;
        if (m > 16) m = 16;
        return m;
    endfunction

    task automatic push_sample(int v, int tc);
        exp_val.push_back(v);
        exp_cyc.push_back(tc + 3);
    endtask

    task automatic do_tick();
        int tc, g;
        @(negedge clk);
        sample_tick = 1'b1;
        tc = cyc;
        if (!m_play) begin
            if (m_pending) begin
                m_play = 1; m_idx = 0; m_last = int'(frame_last); m_pending = 0;
            end else begin
                ur_cyc.push_back(tc + 1);
                push_sample(0, tc);
            end
        end
        if (m_play) begin
            g = model_gain(m_idx, m_last, fade_en);
            push_sample((int'($signed(ram[m_idx])) * g) >>> 4, tc);
            if (m_idx == m_last) begin
                fr_cyc.push_back(tc + 1);
                if (m_pending) begin
                    m_idx = 0; m_last = int'(frame_last); m_pending = 0;
                end else begin
                    m_play = 0;
                end
            end else begin
                m_idx++;
            end
        end
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        frame_done = 1'b1;
        if (m_pending) m_overrun = 1;
        m_pending = 1;
        @(negedge clk);
        frame_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(string tag);
        repeat (8) @(negedge clk);
        check({tag, "_audio_left"}, exp_val.size(), 0);
        check({tag, "_underrun_left"}, ur_cyc.size(), 0);
        check({tag, "_frame_req_left"}, fr_cyc.size(), 0);
        check({tag, "_overrun"}, int'(overrun), int'(m_overrun));
    endtask

    task automatic check_zero_outputs(string tag);
        check({tag, "_rd_addr"}, int'(rd_addr), 0);
        check({tag, "_audio_out"}, int'(audio_out), 0);
        check({tag, "_audio_valid"}, int'(audio_valid), 0);
        check({tag, "_frame_req"}, int'(frame_req), 0);
        check({tag, "_underrun"}, int'(underrun), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 16'(i);
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: full ramp frame at unity gain; frame_last changes after start must be ignored
        fade_en = 1'b0;
        frame_last = 10'd1023;
        frame_pulse();
        do_tick();
        frame_last = 10'd7;
        for (int i = 1; i < 1024; i++) do_tick();
        drain("t1");

        // 2: constant -100 with edge fades
        for (int i = 0; i < 1024; i++) ram[i] = 16'hFF9C;
        fade_en = 1'b1;
        frame_last = 10'd1023;
        frame_pulse();
        for (int i = 0; i < 1024; i++) do_tick();
        drain("t2");

        // 3: underrun ticks leave rd_addr alone
        for (int i = 0; i < 3; i++) do_tick();
        check("t3_rd_addr_hold", int'(rd_addr), 1023);
        drain("t3");

        // 4: back-to-back frames and overrun
        ram[0] = 16'd1000; ram[1] = 16'd700; ram[2] = 16'hFF38; ram[3] = 16'd100;
        fade_en = 1'b0;
        frame_last = 10'd3;
        frame_pulse();
        do_tick();
        do_tick();
        frame_pulse();
        do_tick();
        frame_pulse();
        check("t4_overrun_set", int'(overrun), 1);
        for (int i = 0; i < 5; i++) do_tick();
        do_tick();
        drain("t4");

        // 5: single-sample frame gets zero gain
        ram[0] = 16'd1000;
        fade_en = 1'b1;
        frame_last = 10'd0;
        frame_pulse();
        do_tick();
        do_tick();
        drain("t5");
        check("t5_overrun_sticky", int'(overrun), 1);

        // 6: reset in the middle of a frame
        for (int i = 0; i < 1024; i++) ram[i] = 16'(i);
        fade_en = 1'b0;
        frame_last = 10'd1023;
        frame_pulse();
        for (int i = 0; i <= 500; i++) do_tick();
        check("t6_rd_addr_pre", int'(rd_addr), 500);
        check("t6_audio_pre", int'(audio_out), 500);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("t6_reset");
        m_play = 0; m_pending = 0; m_idx = 0; m_last = 0; m_overrun = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_tick();
        do_tick();
        drain("t6");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
